// File: rtl/timer_arbiter_if.sv
// Requester and shared-timer signals seen by the timer arbiter.
interface timer_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32
);
    localparam int unsigned OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] cycles;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [OW-1:0]            owner;
    logic                     timer_go;
    logic [WIDTH-1:0]         timer_cycles;
    logic                     timer_done;

    // Requesters plus the shared timer.
    modport master (
        output req, cycles, timer_done,
        input  ack, done, busy, owner, timer_go, timer_cycles
    );

    // The arbiter itself.
    modport slave (
        input  req, cycles, timer_done,
        output ack, done, busy, owner, timer_go, timer_cycles
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that hands one shared cycle timer to NUM_REQ requesters.
module timer_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32
) (
    input  logic          clk,
    input  logic          rst,
    timer_arbiter_if.slave bus
);
    localparam int unsigned OW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StZero} state_e;

    state_e             state_q, state_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_q, last_d;
    logic [WIDTH-1:0]   tcyc_q, tcyc_d;
    logic [NUM_REQ-1:0] done_q, done_d;

    logic               found;
    logic [OW-1:0]      winner;
    logic [OW-1:0]      cand;
    logic [31:0]        idx;
    logic [WIDTH-1:0]   sel_cycles;
    logic [NUM_REQ-1:0] ack;
    logic               timer_go;
    logic               busy;

    // Scan from the requester after the last winner, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx  = (32'(last_q) + i) % NUM_REQ;
            cand = OW'(idx);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign sel_cycles = bus.cycles[32'(winner) * WIDTH +: WIDTH];

    // Next-state logic and Moore outputs; done is registered via done_d.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        tcyc_d   = tcyc_q;
        done_d   = '0;
        ack      = '0;
        timer_go = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (found) begin
                    owner_d = winner;
                    last_d  = winner;
                    tcyc_d  = sel_cycles;
                    state_d = (sel_cycles != '0) ? StStart : StZero;
                end
            end
            StStart: begin
                timer_go     = 1'b1;
                ack[owner_q] = 1'b1;
                state_d      = StWait;
            end
            StWait: begin
                if (bus.timer_done) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = StIdle;
                end
            end
            StZero: begin
                // Zero-length grant: acknowledge without starting the timer.
                ack[owner_q]    = 1'b1;
                done_d[owner_q] = 1'b1;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset gives requester 0 the first grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= OW'(NUM_REQ - 1);
            tcyc_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tcyc_q  <= tcyc_d;
            done_q  <= done_d;
        end
    end

    assign bus.ack          = ack;
    assign bus.done         = done_q;
    assign bus.busy         = busy;
    assign bus.owner        = owner_q;
    assign bus.timer_go     = timer_go;
    assign bus.timer_cycles = tcyc_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: directed scenarios plus a random soak,
// all compared cycle by cycle against a grant-timeline model.
module tb_timer_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    timer_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    timer_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared timer: done is high when idle, and once the count reaches target.
    logic             t_run;
    logic [WIDTH-1:0] t_cnt;
    logic [WIDTH-1:0] t_tgt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_run <= 1'b0;
            t_cnt <= '0;
            t_tgt <= '0;
        end else if (bus.timer_go) begin
            t_run <= 1'b1;
            t_cnt <= 1;
            t_tgt <= bus.timer_cycles;
        end else if (t_run && t_cnt >= t_tgt) begin
            t_run <= 1'b0;
        end else if (t_run) begin
            t_cnt <= t_cnt + 1;
        end
    end
    assign bus.timer_done = !t_run || (t_cnt >= t_tgt);

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    // Model: timeline of the current grant, expressed as absolute cycle numbers.
    int free_at, ack_at, ack_w, go_at, done_at, done_w, busy_from, busy_to;
    int m_owner, m_last;
    logic [WIDTH-1:0] m_tc;

    // Observations taken from the DUT for directed checks.
    int obs_ack_cyc  [NUM_REQ];
    int obs_done_cyc [NUM_REQ];
    int obs_ack_tc   [NUM_REQ];
    int obs_done_busy[NUM_REQ];
    int obs_go_cyc;
    int wait_cnt     [NUM_REQ];
    int grant_log[$];
    int done_log[$];
    logic [NUM_REQ-1:0] hold;
    logic [NUM_REQ-1:0] ack_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    endtask

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_clear();
        free_at   = 0;
        ack_at    = -1;
        go_at     = -1;
        done_at   = -1;
        ack_w     = 0;
        done_w    = 0;
        busy_from = 1;
        busy_to   = 0;
        m_owner   = 0;
        m_tc      = '0;
        m_last    = NUM_REQ - 1;
    endtask

    task automatic clear_obs();
        for (int i = 0; i < NUM_REQ; i++) begin
            obs_ack_cyc[i]   = -1;
            obs_done_cyc[i]  = -1;
            obs_ack_tc[i]    = -1;
            obs_done_busy[i] = -1;
            wait_cnt[i]      = 0;
        end
        obs_go_cyc = -1;
        grant_log.delete();
        done_log.delete();
    endtask

    task automatic set_cyc(input int i, input int v);
        bus.cycles[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    // One clock cycle: compare at the falling edge, advance the model, then
    // return just after the rising edge so the caller can change inputs.
    task automatic tick();
        logic [NUM_REQ-1:0] e_ack, e_done;
        logic e_busy, e_go;
        int w, c;
        @(negedge clk);
        ack_seen = bus.ack;
        if (!rst) begin
            check("rst_ack", bus.ack, 0);
            check("rst_done", bus.done, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_go", bus.timer_go, 0);
            check("rst_owner", bus.owner, 0);
            check("rst_tcyc", bus.timer_cycles, 0);
            model_clear();
        end else begin
            e_ack = '0;
            e_done = '0;
            if (cyc == ack_at) e_ack[ack_w] = 1'b1;
            if (cyc == done_at) e_done[done_w] = 1'b1;
            e_busy = (cyc >= busy_from) && (cyc <= busy_to);
            e_go = (cyc == go_at);
            check("ack", bus.ack, e_ack);
            check("done", bus.done, e_done);
            check("busy", bus.busy, e_busy);
            check("timer_go", bus.timer_go, e_go);
            check("ack_onehot", $onehot0(bus.ack), 1);
            if (e_busy) begin
                check("owner", bus.owner, m_owner);
                check("timer_cycles", bus.timer_cycles, m_tc);
            end
            if (cyc >= free_at && bus.req != '0) begin
                w = rr_pick(m_last, bus.req);
                c = int'(bus.cycles[w*WIDTH +: WIDTH]);
                ack_at    = cyc + 1;
                ack_w     = w;
                go_at     = (c != 0) ? cyc + 1 : -1;
                done_at   = cyc + 2 + c;
                done_w    = w;
                busy_from = cyc + 1;
                busy_to   = cyc + 1 + c;
                m_owner   = w;
                m_tc      = WIDTH'(c);
                m_last    = w;
                free_at   = cyc + 2 + c;
            end
        end
        if (bus.timer_go) obs_go_cyc = cyc;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.ack[i]) begin
                obs_ack_cyc[i] = cyc;
                obs_ack_tc[i]  = int'(bus.timer_cycles);
                grant_log.push_back(i);
                check("starvation", wait_cnt[i] <= NUM_REQ, 1);
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (j != i && bus.req[j]) wait_cnt[j]++;
                end
                wait_cnt[i] = 0;
            end
            if (!bus.req[i]) wait_cnt[i] = 0;
            if (bus.done[i]) begin
                obs_done_cyc[i]  = cyc;
                obs_done_busy[i] = int'(bus.busy);
                done_log.push_back(cyc);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_seen[i] && !hold[i]) bus.req[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        clear_obs();
    endtask

    int t;
    initial begin
        bus.req    = '0;
        bus.cycles = '0;
        hold       = '0;
        ack_seen   = '0;
        model_clear();
        clear_obs();
        tick();
        tick();
        rst = 1'b1;

        // Single request, five-cycle interval.
        do_reset();
        set_cyc(2, 5);
        bus.req[2] = 1'b1;
        t = cyc;
        repeat (10) tick();
        check("single_ack_cyc", obs_ack_cyc[2], t + 1);
        check("single_go_cyc", obs_go_cyc, t + 1);
        check("single_tcyc", obs_ack_tc[2], 5);
        check("single_done_cyc", obs_done_cyc[2], t + 7);
        check("single_busy_at_done", obs_done_busy[2], 0);

        // All four requesting continuously, one-cycle intervals.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_cyc(i, 1);
        hold    = '1;
        bus.req = '1;
        repeat (16) tick();
        check("rr_count", grant_log.size() >= 5, 1);
        if (grant_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("rr_order", grant_log[k], k % NUM_REQ);
        end
        check("rr_done_count", done_log.size() >= 5, 1);
        if (done_log.size() >= 5) begin
            for (int k = 0; k < 4; k++) check("rr_spacing", done_log[k+1] - done_log[k], 3);
        end
        hold    = '0;
        bus.req = '0;
        repeat (6) tick();

        // Zero-length request.
        do_reset();
        set_cyc(1, 0);
        bus.req[1] = 1'b1;
        t = cyc;
        repeat (5) tick();
        check("zero_ack_cyc", obs_ack_cyc[1], t + 1);
        check("zero_done_cyc", obs_done_cyc[1], t + 2);
        check("zero_no_go", obs_go_cyc, -1);

        // Request arriving while the timer is owned.
        do_reset();
        set_cyc(3, 1);
        bus.req[3] = 1'b1;
        t = cyc;
        tick();
        tick();
        set_cyc(0, 2);
        bus.req[0] = 1'b1;
        repeat (8) tick();
        check("wait_done3_cyc", obs_done_cyc[3], t + 3);
        check("wait_ack0_cyc", obs_ack_cyc[0], t + 4);

        // Reset in the middle of a long interval.
        do_reset();
        set_cyc(1, 100);
        bus.req[1] = 1'b1;
        t = cyc;
        repeat (20) tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (110) tick();
        check("abort_no_done", obs_done_cyc[1], -1);
        set_cyc(0, 3);
        set_cyc(1, 3);
        bus.req[0] = 1'b1;
        bus.req[1] = 1'b1;
        t = cyc;
        repeat (20) tick();
        check("abort_first_grant", obs_ack_cyc[0], t + 1);
        check("abort_second_grant", obs_ack_cyc[1], t + 6);

        // Random soak.
        do_reset();
        repeat (10000) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hold[i] = ($urandom_range(3) == 0);
                if (!bus.req[i] && $urandom_range(3) == 0) begin
                    set_cyc(i, int'($urandom_range(20)));
                    bus.req[i] = 1'b1;
                end
            end
            tick();
        end
        hold    = '0;
        bus.req = '0;
        repeat (30) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
